// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_IE   = 2'd2,
    OWN_DMA  = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  // Deepest RAM read latency the wait counter is sized for.
  localparam int ARB_RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: DMA > IE > IF, with IF lifted above IE
// (never above DMA) while the starvation boost flag is set.
module mem_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic   dma_req,
  input  logic   ie_req,
  input  logic   if_req,
  input  logic   boost,
  output owner_t win
);

  // Priority chain; boost only reorders IF against IE.
  always_comb begin
    win = OWN_NONE;
    if (dma_req)              win = OWN_DMA;
    else if (if_req && boost) win = OWN_IF;
    else if (ie_req)          win = OWN_IE;
    else if (if_req)          win = OWN_IF;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port RAM arbiter for DMA, execute-unit and fetch requesters.
// One transaction at a time; fixed priority DMA > IE > IF.
// Optional build macro ARB_FETCH_BOOST_EN: after STARVE_MAX consecutive
// lost arbitrations, fetch is promoted above IE until it is granted.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | no transaction; arbitrate requests on each clock edge
// ST_ISSUE  | address on RAM, grant pulse high; writes strobe mem_we
// ST_WAIT   | read in flight, count RD_LAT cycles then capture data
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  input  logic              ie_req,
  input  logic              ie_we,
  input  logic [ADDR_W-1:0] ie_addr,
  input  logic [DATA_W-1:0] ie_wdata,
  output logic              ie_gnt,
  output logic              ie_rvalid,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        owner
);

  localparam logic [1:0] ST_IDLE  = ARB_IDLE;
  localparam logic [1:0] ST_ISSUE = ARB_ISSUE;
  localparam logic [1:0] ST_WAIT  = ARB_WAIT;

  localparam int              LAT_W    = $clog2(ARB_RD_LAT_MAX);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  logic [1:0]        state;
  logic [LAT_W-1:0]  lat_cnt;
  owner_t            owner_q;
  owner_t            win;
  logic              boost;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_we;

  assign owner = owner_q;

`ifdef ARB_FETCH_BOOST_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;

  assign boost = (starve_cnt >= STARVE_TOP);

  // Count IDLE arbitrations that fetch loses; clear when fetch wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (win == OWN_IF)
        starve_cnt <= '0;
      else if (if_req && (starve_cnt != STARVE_TOP))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  localparam int unused_starve_max = STARVE_MAX;

  assign boost = 1'b0;
`endif

  mem_arb_pick u_pick (
    .dma_req (dma_req),
    .ie_req  (ie_req),
    .if_req  (if_req),
    .boost   (boost),
    .win     (win)
  );

  // Route the winning requester's command toward the latch in IDLE.
  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_we    = 1'b0;
    case (win)
      OWN_DMA: begin
        win_addr  = dma_addr;
        win_wdata = dma_wdata;
        win_we    = dma_we;
      end
      OWN_IE: begin
        win_addr  = ie_addr;
        win_wdata = ie_wdata;
        win_we    = ie_we;
      end
      OWN_IF: begin
        win_addr  = if_addr;
      end
      default: ;
    endcase
  end

  // Transaction sequencer; strobes default low and pulse for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      owner_q    <= OWN_NONE;
      busy       <= 1'b0;
      dma_gnt    <= 1'b0;
      ie_gnt     <= 1'b0;
      if_gnt     <= 1'b0;
      dma_rvalid <= 1'b0;
      ie_rvalid  <= 1'b0;
      if_rvalid  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      rd_data    <= '0;
    end else begin
      dma_gnt    <= 1'b0;
      ie_gnt     <= 1'b0;
      if_gnt     <= 1'b0;
      dma_rvalid <= 1'b0;
      ie_rvalid  <= 1'b0;
      if_rvalid  <= 1'b0;
      mem_we     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win != OWN_NONE) begin
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            mem_we    <= win_we;
            owner_q   <= win;
            busy      <= 1'b1;
            dma_gnt   <= (win == OWN_DMA);
            ie_gnt    <= (win == OWN_IE);
            if_gnt    <= (win == OWN_IF);
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (mem_we) begin
            owner_q <= OWN_NONE;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            lat_cnt <= '0;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rd_data    <= mem_rdata;
            dma_rvalid <= (owner_q == OWN_DMA);
            ie_rvalid  <= (owner_q == OWN_IE);
            if_rvalid  <= (owner_q == OWN_IF);
            owner_q    <= OWN_NONE;
            busy       <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a grant-order and read-data
// scoreboard. Build with ARB_FETCH_BOOST_EN to exercise fetch boost.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  typedef struct {
    logic [1:0] own;
    logic [7:0] data;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dma_req = 0, dma_we = 0, ie_req = 0, ie_we = 0, if_req = 0;
  logic [15:0] dma_addr = 0, ie_addr = 0, if_addr = 0;
  logic [7:0]  dma_wdata = 0, ie_wdata = 0;
  logic        dma_gnt, dma_rvalid, ie_gnt, ie_rvalid, if_gnt, if_rvalid;
  logic [7:0]  rd_data, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
  logic        mem_we, busy;
  logic [1:0]  owner;

  logic [7:0]  ram [0:65535];
  logic [1:0]  gq[$];
  rd_exp_t     rq[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          we_cnt = 0;
  int          ie_gcnt = 0;
  int          if_gcnt = 0;
  logic        hold_ie = 1'b0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .ie_req(ie_req), .ie_we(ie_we), .ie_addr(ie_addr), .ie_wdata(ie_wdata),
    .ie_gnt(ie_gnt), .ie_rvalid(ie_rvalid),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .rd_data(rd_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  // Synchronous RAM, one cycle read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: grant order and read returns.
  always @(negedge clk) begin : mon
    logic [1:0] got;
    logic [1:0] eg;
    rd_exp_t    er;
    if (mem_we) we_cnt++;
    if (dma_gnt || ie_gnt || if_gnt) begin
      got = dma_gnt ? 2'd3 : (ie_gnt ? 2'd2 : 2'd1);
      chk("gnt_onehot", 32'($onehot({dma_gnt, ie_gnt, if_gnt})), 32'd1);
      chk("gnt_expected", 32'(gq.size() != 0), 32'd1);
      if (gq.size() != 0) begin
        eg = gq.pop_front();
        chk("gnt_order", 32'(got), 32'(eg));
      end
    end
    if (dma_rvalid || ie_rvalid || if_rvalid) begin
      got = dma_rvalid ? 2'd3 : (ie_rvalid ? 2'd2 : 2'd1);
      chk("rvalid_onehot", 32'($onehot({dma_rvalid, ie_rvalid, if_rvalid})), 32'd1);
      chk("rvalid_expected", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0) begin
        er = rq.pop_front();
        chk("rvalid_owner", 32'(got), 32'(er.own));
        chk("rd_data", 32'(rd_data), 32'(er.data));
      end
    end
  end

  // One clock; requesters drop req in the cycle they see their grant.
  task automatic step();
    @(posedge clk);
    #1;
    if (dma_gnt) dma_req = 1'b0;
    if (ie_gnt) begin
      ie_gcnt++;
      if (!hold_ie) ie_req = 1'b0;
    end
    if (if_gnt) begin
      if_gcnt++;
      if_req = 1'b0;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((gq.size() != 0 || rq.size() != 0 || dma_req || ie_req || if_req || busy)
           && n < budget) begin
      step();
      n++;
    end
    step();
    chk({tag, "_drained"}, 32'(gq.size() + rq.size()), 32'd0);
    chk({tag, "_idle"}, {29'd0, busy, owner}, 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    ram[16'h0010] = 8'h11;
    ram[16'h0020] = 8'h22;
    ram[16'h0100] = 8'hA9;

    // Reset held with all requests raised.
    dma_req = 1; dma_addr = 16'h0010;
    ie_req  = 1; ie_addr  = 16'h0020;
    if_req  = 1; if_addr  = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_strobes", {24'd0, dma_gnt, ie_gnt, if_gnt, dma_rvalid, ie_rvalid,
                            if_rvalid, mem_we, busy}, 32'd0);
      chk("reset_owner", 32'(owner), 32'd0);
      chk("reset_bus", {mem_addr, mem_wdata, rd_data}, 32'd0);
    end

    // Release: simultaneous requests served DMA, IE, IF.
    gq.push_back(2'd3); gq.push_back(2'd2); gq.push_back(2'd1);
    rq.push_back('{2'd3, 8'h11});
    rq.push_back('{2'd2, 8'h22});
    rq.push_back('{2'd1, 8'hA9});
    rst = 1'b1;
    step();
    chk("first_gnt_dma", {29'd0, dma_gnt, ie_gnt, if_gnt}, 32'b100);
    chk("first_owner", 32'(owner), 32'd3);
    chk("first_addr", 32'(mem_addr), 32'h0010);
    drain("simul", 40);

    // Single IF read timing: gnt at +1, rvalid at +3.
    if_req = 1; if_addr = 16'h0100;
    gq.push_back(2'd1); rq.push_back('{2'd1, 8'hA9});
    step();
    chk("if_gnt_p1", 32'(if_gnt), 32'd1);
    chk("if_busy_p1", 32'(busy), 32'd1);
    step();
    chk("if_rvalid_p2", 32'(if_rvalid), 32'd0);
    step();
    chk("if_rvalid_p3", 32'(if_rvalid), 32'd1);
    chk("if_data_p3", 32'(rd_data), 32'hA9);
    drain("if_read", 10);

    // IE write then IF read of the same address; address latched at grant.
    n = we_cnt;
    ie_req = 1; ie_we = 1; ie_addr = 16'h0200; ie_wdata = 8'h5C;
    gq.push_back(2'd2);
    step();
    chk("wr_strobe", {7'd0, mem_we, mem_addr, mem_wdata}, {7'd0, 1'b1, 16'h0200, 8'h5C});
    ie_we = 0; ie_wdata = 8'h00; ie_addr = 16'h0020;
    step();
    chk("wr_strobe_end", 32'(mem_we), 32'd0);
    if_req = 1; if_addr = 16'h0200;
    gq.push_back(2'd1); rq.push_back('{2'd1, 8'h5C});
    step();
    chk("rd_after_wr_gnt", 32'(if_gnt), 32'd1);
    if_addr = 16'h0100;
    drain("wr_rd", 10);
    chk("we_pulses", 32'(we_cnt - n), 32'd1);
    chk("rd_hold", 32'(rd_data), 32'h5C);

    // Reset during WAIT drops the read.
    if_req = 1; if_addr = 16'h0100;
    gq.push_back(2'd1);
    step();
    step();
    rst = 1'b0;
    rq.delete();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_quiet", {29'd0, if_rvalid, busy, mem_we}, 32'd0);
    end
    rst = 1'b1;
    if_req = 1; if_addr = 16'h0200;
    gq.push_back(2'd1); rq.push_back('{2'd1, 8'h5C});
    drain("post_rst", 10);

    // IE held high alongside IF.
    ie_gcnt = 0; if_gcnt = 0;
    hold_ie = 1'b1;
    ie_req = 1; ie_we = 0; ie_addr = 16'h0020;
    if_req = 1; if_addr = 16'h0100;
`ifdef ARB_FETCH_BOOST_EN
    for (int i = 0; i < 4; i++) begin
      gq.push_back(2'd2); rq.push_back('{2'd2, 8'h22});
    end
    gq.push_back(2'd1); rq.push_back('{2'd1, 8'hA9});
    gq.push_back(2'd2); rq.push_back('{2'd2, 8'h22});
    n = 0;
    while (if_gcnt == 0 && n < 40) begin
      step();
      n++;
    end
    chk("boost_if_gnt", 32'(if_gcnt), 32'd1);
    chk("boost_ie_before", 32'(ie_gcnt), 32'd4);
    hold_ie = 1'b0;
    drain("boost", 20);
`else
    for (int i = 0; i < 6; i++) begin
      gq.push_back(2'd2); rq.push_back('{2'd2, 8'h22});
    end
    n = 0;
    while (ie_gcnt < 6 && n < 40) begin
      step();
      n++;
    end
    chk("fixed_ie_gnts", 32'(ie_gcnt), 32'd6);
    chk("fixed_if_starved", 32'(if_gcnt), 32'd0);
    hold_ie = 1'b0;
    ie_req = 1'b0;
    gq.push_back(2'd1); rq.push_back('{2'd1, 8'hA9});
    drain("fixed", 20);
    chk("fixed_if_late", 32'(if_gcnt), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
